// File: rtl/ysyx_22050854_mdu_pkg.sv
// Shared op codes, FSM state and width constants for the iterative RV64M unit.
package ysyx_22050854_mdu_pkg;
  localparam int MDU_XLEN = 64;
  localparam int CNT_W    = 7;

  localparam logic [3:0] OP_MUL    = 4'b1001;
  localparam logic [3:0] OP_MULH   = 4'b0001;
  localparam logic [3:0] OP_MULHSU = 4'b0010;
  localparam logic [3:0] OP_MULHU  = 4'b0011;
  localparam logic [3:0] OP_DIV    = 4'b0100;
  localparam logic [3:0] OP_DIVU   = 4'b0101;
  localparam logic [3:0] OP_REM    = 4'b0110;
  localparam logic [3:0] OP_REMU   = 4'b0111;
  localparam logic [3:0] OP_MULW   = 4'b1000;
  localparam logic [3:0] OP_DIVW   = 4'b1100;
  localparam logic [3:0] OP_DIVUW  = 4'b1101;
  localparam logic [3:0] OP_REMW   = 4'b1110;
  localparam logic [3:0] OP_REMUW  = 4'b1111;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction
endpackage

// File: rtl/ysyx_22050854_mdu_prep.sv
// Combinational operand preparation: decode, W extension, magnitudes, result signs,
// and the divide-by-zero / signed-overflow short-circuit result.
module ysyx_22050854_mdu_prep
  import ysyx_22050854_mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [63:0] src1,
  input  logic [63:0] src2,
  output logic        legal,
  output logic        is_div,
  output logic        is_rem,
  output logic        is_w,
  output logic        is_hi,
  output logic [63:0] a_mag,
  output logic [63:0] b_mag,
  output logic        neg_q,
  output logic        neg_r,
  output logic        short_vld,
  output logic [63:0] short_res
);
  logic        sgn_a, sgn_b, a_neg, b_neg, div_zero, div_ovf;
  logic [63:0] a_ext, b_ext, a_res;

  always_comb begin
    legal = 1'b1; is_div = 1'b0; is_rem = 1'b0; is_w = 1'b0; is_hi = 1'b0;
    sgn_a = 1'b0; sgn_b = 1'b0;
    case (op)
      OP_MUL:    begin sgn_a = 1'b1; sgn_b = 1'b1; end
      OP_MULH:   begin is_hi = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; end
      OP_MULHSU: begin is_hi = 1'b1; sgn_a = 1'b1; end
      OP_MULHU:  is_hi = 1'b1;
      OP_DIV:    begin is_div = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; end
      OP_DIVU:   is_div = 1'b1;
      OP_REM:    begin is_div = 1'b1; is_rem = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; end
      OP_REMU:   begin is_div = 1'b1; is_rem = 1'b1; end
      OP_MULW:   begin is_w = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; end
      OP_DIVW:   begin is_w = 1'b1; is_div = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; end
      OP_DIVUW:  begin is_w = 1'b1; is_div = 1'b1; end
      OP_REMW:   begin is_w = 1'b1; is_div = 1'b1; is_rem = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; end
      OP_REMUW:  begin is_w = 1'b1; is_div = 1'b1; is_rem = 1'b1; end
      default:   legal = 1'b0;
    endcase
  end

  assign a_ext = is_w ? (sgn_a ? sext32(src1[31:0]) : {32'd0, src1[31:0]}) : src1;
  assign b_ext = is_w ? (sgn_b ? sext32(src2[31:0]) : {32'd0, src2[31:0]}) : src2;
  assign a_neg = sgn_a & a_ext[63];
  assign b_neg = sgn_b & b_ext[63];
  assign a_mag = a_neg ? -a_ext : a_ext;
  assign b_mag = b_neg ? -b_ext : b_ext;
  assign neg_q = a_neg ^ b_neg;
  assign neg_r = a_neg;

  // W results are always sign-extended, even for the unsigned variants.
  assign a_res    = is_w ? sext32(src1[31:0]) : src1;
  assign div_zero = is_div && (b_ext == '0);
  assign div_ovf  = is_div && sgn_a && (b_ext == '1) &&
                    (a_ext == (is_w ? sext32(32'h8000_0000) : 64'h8000_0000_0000_0000));
  assign short_vld = div_zero | div_ovf;
  assign short_res = div_zero ? (is_rem ? a_res : '1) : (is_rem ? '0 : a_res);
endmodule

// File: rtl/ysyx_22050854_mdu.sv
// Iterative RV64M multiply/divide: shift-add multiply, restoring divide, one bit per cycle.
// out_valid N+1 cycles after acceptance (N=64, 32 for W); result held until out_ready.
module ysyx_22050854_mdu
  import ysyx_22050854_mdu_pkg::*;
#(
  parameter int XLEN = MDU_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      MULctr,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  state_e           state;
  logic [CNT_W-1:0] cnt, cnt_nx, n_iter;
  logic [127:0]     acc, acc_nx, mcand, mcand_nx, prod;
  logic [63:0]      mplier, mplier_nx, quo, rmd, fin_raw, fin;
  logic [64:0]      rem_sh;
  logic [63:0]      rem_df;
  logic             ge;
  logic             op_div, op_rem, op_w, op_hi, neg_q, neg_r;

  logic        p_legal, p_div, p_rem, p_w, p_hi, p_neg_q, p_neg_r, p_short;
  logic [63:0] p_a_mag, p_b_mag, p_short_res;

  ysyx_22050854_mdu_prep u_prep (
    .op        (MULctr),
    .src1      (src1),
    .src2      (src2),
    .legal     (p_legal),
    .is_div    (p_div),
    .is_rem    (p_rem),
    .is_w      (p_w),
    .is_hi     (p_hi),
    .a_mag     (p_a_mag),
    .b_mag     (p_b_mag),
    .neg_q     (p_neg_q),
    .neg_r     (p_neg_r),
    .short_vld (p_short),
    .short_res (p_short_res)
  );

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign cnt_nx    = cnt + 1'b1;

  // mul: acc += mcand when the multiplier LSB is set. div: acc[63:0] is the partial
  // remainder, mcand[63:0] the divisor, mplier shifts dividend bits out and quotient bits in.
  always_comb begin
    acc_nx = acc; mcand_nx = mcand; mplier_nx = mplier;
    rem_sh = '0; rem_df = '0; ge = 1'b0;
    if (op_div) begin
      rem_sh    = {acc[63:0], mplier[63]};
      ge        = rem_sh >= {1'b0, mcand[63:0]};
      rem_df    = rem_sh[63:0] - mcand[63:0];
      acc_nx    = {64'd0, ge ? rem_df : rem_sh[63:0]};
      mplier_nx = {mplier[62:0], ge};
    end else begin
      acc_nx    = acc + (mplier[0] ? mcand : 128'd0);
      mcand_nx  = mcand << 1;
      mplier_nx = mplier >> 1;
    end
  end

  always_comb begin
    prod    = neg_q ? -acc_nx : acc_nx;
    quo     = neg_q ? -mplier_nx : mplier_nx;
    rmd     = neg_r ? -acc_nx[63:0] : acc_nx[63:0];
    fin_raw = op_div ? (op_rem ? rmd : quo) : (op_hi ? prod[127:64] : prod[63:0]);
    fin     = op_w ? sext32(fin_raw[31:0]) : fin_raw;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      n_iter <= '0;
      result <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      op_div <= 1'b0; op_rem <= 1'b0; op_w <= 1'b0; op_hi <= 1'b0;
      neg_q  <= 1'b0; neg_r  <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (in_valid && p_legal) begin
          op_div <= p_div; op_rem <= p_rem; op_w <= p_w; op_hi <= p_hi;
          neg_q  <= p_neg_q; neg_r <= p_neg_r;
          cnt    <= '0;
          n_iter <= p_w ? 7'd32 : 7'd64;
          acc    <= '0;
          mcand  <= {64'd0, p_div ? p_b_mag : p_a_mag};
          // W divides pre-shift the dividend so its bit 31 is consumed first.
          mplier <= p_div ? (p_w ? {p_a_mag[31:0], 32'd0} : p_a_mag) : p_b_mag;
          if (p_short) begin
            result <= p_short_res;
            state  <= DONE;
          end else begin
            state <= CALC;
          end
        end
        CALC: begin
          acc    <= acc_nx;
          mcand  <= mcand_nx;
          mplier <= mplier_nx;
          cnt    <= cnt_nx;
          if (cnt_nx == n_iter) begin
            result <= fin;
            state  <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_22050854_mdu.sv
// Randomized and directed checks of the MDU against a plain-arithmetic reference model.
module tb_ysyx_22050854_mdu;
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, busy;
  logic [3:0]  mul_ctr = 4'd0;
  logic [63:0] src1 = '0, src2 = '0, result;
  int          total = 0, bad = 0;

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  always #5 clk = ~clk;

  ysyx_22050854_mdu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .MULctr    (mul_ctr),
    .src1      (src1),
    .src2      (src2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Reference results straight from the RV64M definitions.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] pa, pb, p;
    logic signed [63:0]  sa, sb;
    logic signed [31:0]  wa, wb;
    logic [31:0]         ua, ub, r32;
    sa = a; sb = b; wa = a[31:0]; wb = b[31:0]; ua = a[31:0]; ub = b[31:0];
    case (op)
      4'b1001: return a * b;
      4'b0001: begin pa = {{64{a[63]}}, a}; pb = {{64{b[63]}}, b}; p = pa * pb; return p[127:64]; end
      4'b0010: begin pa = {{64{a[63]}}, a}; pb = {64'd0, b}; p = pa * pb; return p[127:64]; end
      4'b0011: begin pa = {64'd0, a}; pb = {64'd0, b}; p = pa * pb; return p[127:64]; end
      4'b1000: begin r32 = ua * ub; return sx(r32); end
      4'b0100: begin
        if (b == 0) return ONES;
        if (a == MIN64 && b == ONES) return a;
        return sa / sb;
      end
      4'b0101: return (b == 0) ? ONES : a / b;
      4'b0110: begin
        if (b == 0) return a;
        if (a == MIN64 && b == ONES) return 64'd0;
        return sa % sb;
      end
      4'b0111: return (b == 0) ? a : a % b;
      4'b1100: begin
        if (ub == 0) return ONES;
        if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) return sx(ua);
        r32 = wa / wb; return sx(r32);
      end
      4'b1101: begin
        if (ub == 0) return ONES;
        r32 = ua / ub; return sx(r32);
      end
      4'b1110: begin
        if (ub == 0) return sx(ua);
        if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) return 64'd0;
        r32 = wa % wb; return sx(r32);
      end
      4'b1111: begin
        if (ub == 0) return sx(ua);
        r32 = ua % ub; return sx(r32);
      end
      default: return 64'd0;
    endcase
  endfunction

  // Clock edges after the acceptance edge until out_valid is seen.
  function automatic int exp_lat(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    bit w, dv, sg, zero, ovf;
    dv   = op[2];
    w    = op[3] && (op != 4'b1001);
    sg   = dv && !op[0];
    zero = w ? (b[31:0] == 0) : (b == 0);
    ovf  = sg && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                    : (a == MIN64 && b == ONES));
    if (dv && (zero || ovf)) return 0;
    return w ? 32 : 64;
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b, input int hold);
    logic [63:0] exp;
    int          lat, edges;
    exp = model(op, a, b);
    lat = exp_lat(op, a, b);
    check("idle_ready", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1; mul_ctr = op; src1 = a; src2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    mul_ctr = 4'($urandom); src1 = {$urandom, $urandom}; src2 = {$urandom, $urandom};
    edges = 0;
    while (!out_valid && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
    check($sformatf("latency op=%b", op), 64'(edges), 64'(lat));
    check($sformatf("result op=%b a=%h b=%h", op, a, b), result, exp);
    repeat (hold) begin
      @(posedge clk); #1;
      check("hold_result", result, exp);
      check("hold_in_ready", {63'd0, in_ready}, 64'd0);
      check("hold_out_valid", {63'd0, out_valid}, 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_in_ready", {63'd0, in_ready}, 64'd1);
    check("post_out_valid", {63'd0, out_valid}, 64'd0);
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return ONES;
      2: return MIN64;
      3: return ($urandom_range(0, 1) != 0) ? 64'($urandom_range(0, 20)) : -64'($urandom_range(1, 20));
      4: return {$urandom, 32'h8000_0000};
      5: return {$urandom, 32'hFFFF_FFFF};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  logic [3:0] codes [13] = '{4'b1001, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110,
                             4'b0111, 4'b1000, 4'b1100, 4'b1101, 4'b1110, 4'b1111};
  logic [3:0] bad_codes [3] = '{4'b0000, 4'b1010, 4'b1011};

  initial begin
    int seen;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_result", result, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(4'b1001, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 0);
    run_op(4'b0011, ONES, ONES, 0);
    run_op(4'b0001, ONES, ONES, 0);
    run_op(4'b0100, 64'd7, 64'd0, 0);
    run_op(4'b0110, 64'd7, 64'd0, 0);
    run_op(4'b0100, MIN64, ONES, 0);
    run_op(4'b0110, MIN64, ONES, 0);
    run_op(4'b1100, 64'h0000_0001_FFFF_FFF9, 64'd2, 5);
    run_op(4'b1110, 64'h0000_0001_FFFF_FFF9, 64'd2, 0);
    run_op(4'b0010, MIN64, ONES, 5);

    foreach (bad_codes[i]) begin
      in_valid = 1'b1; mul_ctr = bad_codes[i]; src1 = 64'd5; src2 = 64'd3;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("illegal_in_ready", {63'd0, in_ready}, 64'd1);
      check("illegal_busy", {63'd0, busy}, 64'd0);
      seen = 0;
      repeat (3) begin @(posedge clk); #1; if (out_valid) seen++; end
      check("illegal_no_valid", 64'(seen), 64'd0);
    end

    // Flush ten cycles into a 64-bit divide.
    in_valid = 1'b1; mul_ctr = 4'b0100; src1 = 64'd1000; src2 = 64'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("flush_busy_before", {63'd0, busy}, 64'd1);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_in_ready", {63'd0, in_ready}, 64'd1);
    check("flush_busy", {63'd0, busy}, 64'd0);
    seen = 0;
    repeat (80) begin @(posedge clk); #1; if (out_valid) seen++; end
    check("flush_no_valid", 64'(seen), 64'd0);

    // Reset in the middle of a multiply.
    in_valid = 1'b1; mul_ctr = 4'b1001; src1 = 64'd11; src2 = 64'd13;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    check("midrst_result", result, 64'd0);
    seen = 0;
    repeat (70) begin @(posedge clk); #1; if (out_valid) seen++; end
    check("midrst_no_valid", 64'(seen), 64'd0);

    for (int n = 0; n < 80; n++)
      run_op(codes[$urandom_range(0, 12)], pick(), pick(), $urandom_range(0, 3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
